// File: rtl/teclado_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Holds the frame geometry, the break prefix and the receiver state encoding.
package teclado_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam int         FRAME_BITS = 11;
  localparam int         FILTER_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    DPS,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/teclado_if.sv
// PS/2 pin and key-report bundle between the connector side and the keyboard front end.
// The master drives the pins and the enable; the slave returns the decoded key reports.
interface teclado_if;

  logic       ps2d;
  logic       ps2c;
  logic       rx_en;
  logic       rx_done_tick;
  logic       new_data;
  logic [7:0] letra;

  modport master (
    output ps2d,
    output ps2c,
    output rx_en,
    input  rx_done_tick,
    input  new_data,
    input  letra
  );

  modport slave (
    input  ps2d,
    input  ps2c,
    input  rx_en,
    output rx_done_tick,
    output new_data,
    output letra
  );

endinterface

// File: rtl/teclado_ps2_rx.sv
// PS/2 frame receiver: debounces the keyboard clock, detects its falling edges
// and shifts in 11-bit frames, pulsing rx_done_tick when a frame is complete.
module ps2_rx
  import teclado_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout
);

  logic [FILTER_LEN-1:0] filter_hist;
  logic                  filt_ps2c;
  logic                  filt_next;
  logic                  fall_edge;

  rx_state_t             state;
  logic [FRAME_BITS-1:0] b;
  logic [3:0]            n;
  logic                  unused_start_bit;

  // The filtered level only moves once the whole history agrees, which also
  // resynchronises the asynchronous ps2c line into the clk domain.
  always_comb begin
    filt_next = filt_ps2c;
    if (filter_hist == {FILTER_LEN{1'b1}}) begin
      filt_next = 1'b1;
    end else if (filter_hist == {FILTER_LEN{1'b0}}) begin
      filt_next = 1'b0;
    end
  end

  assign fall_edge = filt_ps2c & ~filt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      filter_hist <= {FILTER_LEN{1'b1}};
      filt_ps2c   <= 1'b1;
    end else begin
      filter_hist <= {ps2c, filter_hist[FILTER_LEN-1:1]};
      filt_ps2c   <= filt_next;
    end
  end

  // Start, parity and stop bits are shifted in but deliberately never checked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      b            <= '0;
      n            <= 4'd0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge && rx_en) begin
            b     <= {ps2d, b[FRAME_BITS-1:1]};
            n     <= 4'd9;
            state <= DPS;
          end
        end
        DPS: begin
          if (fall_edge) begin
            b <= {ps2d, b[FRAME_BITS-1:1]};
            if (n == 4'd0) begin
              state        <= LOAD;
              rx_done_tick <= 1'b1;
            end else begin
              n <= n - 4'd1;
            end
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dout             = b[8:1];
  assign unused_start_bit = b[0];

endmodule

// File: rtl/teclado.sv
// PS/2 keyboard front end: receives frames and reports the scan code that
// follows each break prefix, i.e. the key that was just released.
module teclado #(
  parameter int         FILTER_LEN = 8,
  parameter logic [7:0] BREAK_CODE = teclado_pkg::BREAK_CODE
) (
  input  logic      clk,
  input  logic      reset,
  teclado_if.slave  bus
);

  logic       rx_done;
  logic [7:0] dout;
  logic       break_flag;
  logic [7:0] letra_q;
  logic       new_data_q;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (bus.ps2d),
    .ps2c         (bus.ps2c),
    .rx_en        (bus.rx_en),
    .rx_done_tick (rx_done),
    .dout         (dout)
  );

  // Make codes (and E0 prefixes) arriving without a pending break are dropped;
  // a repeated break prefix simply keeps the flag armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      break_flag <= 1'b0;
      letra_q    <= 8'h00;
      new_data_q <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      if (rx_done) begin
        if (dout == BREAK_CODE) begin
          break_flag <= 1'b1;
        end else if (break_flag) begin
          letra_q    <= dout;
          new_data_q <= 1'b1;
          break_flag <= 1'b0;
        end
      end
    end
  end

  assign bus.rx_done_tick = rx_done;
  assign bus.new_data     = new_data_q;
  assign bus.letra        = letra_q;

endmodule

// File: tb/tb_teclado.sv
// Bench for teclado: directed key sequences followed by random frames, all
// compared against a byte-level model of the break-prefix decoding rules.
`timescale 1ns/1ps
module tb_teclado;

  localparam int         HALF_NS = 200;
  localparam logic [7:0] BRK     = 8'hF0;

  logic clk;
  logic reset;
  teclado_if bus ();

  teclado #(
    .FILTER_LEN (8),
    .BREAK_CODE (8'hF0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  int rx_seen = 0;
  int nd_seen = 0;
  logic prev_rx = 1'b0;

  int         exp_rx = 0;
  int         exp_nd = 0;
  logic [7:0] exp_letra = 8'h00;
  bit         model_brk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pulses are counted per cycle high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) rx_seen++;
    if (bus.new_data === 1'b1) begin
      nd_seen++;
      checkOutput("new_data_latency", {31'd0, prev_rx}, 32'd1);
    end
    prev_rx = bus.rx_done_tick;
  end

  task automatic modelByte(input logic [7:0] v);
    exp_rx++;
    if (v == BRK) begin
      model_brk = 1'b1;
    end else if (model_brk) begin
      exp_letra = v;
      exp_nd++;
      model_brk = 1'b0;
    end
  endtask

  task automatic modelReset();
    exp_letra = 8'h00;
    model_brk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, ~^v, v, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = frame[i];
      #(HALF_NS) bus.ps2c = 1'b0;
      #(HALF_NS) bus.ps2c = 1'b1;
    end
    bus.ps2d = 1'b1;
    #(HALF_NS);
  endtask

  task automatic sendByte(input logic [7:0] v);
    applyStimulus(v, 11);
    if (bus.rx_en) modelByte(v);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_letra"}, {24'd0, bus.letra}, {24'd0, exp_letra});
    checkOutput({tag, "_rx_count"}, rx_seen, exp_rx);
    checkOutput({tag, "_nd_count"}, nd_seen, exp_nd);
  endtask

  initial begin
    logic [7:0] rb;
    bus.ps2c  = 1'b1;
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b0;
    reset     = 1'b1;
    #100;
    bus.rx_en = 1'b1;

    // 1: frame during reset is ignored
    applyStimulus(BRK, 11);
    checkOutput("reset_letra", {24'd0, bus.letra}, 32'h00);
    checkOutput("reset_new_data", {31'd0, bus.new_data}, 32'd0);
    checkOutput("reset_rx_done", {31'd0, bus.rx_done_tick}, 32'd0);
    checkOutput("reset_rx_count", rx_seen, 32'd0);
    reset = 1'b0;
    #100;

    // 2: F0 2B
    sendByte(8'hF0);
    checkAll("break_only");
    sendByte(8'h2B);
    checkAll("release_2B");
    checkOutput("letra_2B_const", {24'd0, bus.letra}, 32'h2B);

    // 3/4: F0 74, lone F0, F0 76 (double break prefix)
    sendByte(8'hF0);
    sendByte(8'h74);
    checkAll("release_74");
    sendByte(8'hF0);
    checkAll("lone_break");
    sendByte(8'hF0);
    sendByte(8'h76);
    checkAll("release_76");
    checkOutput("three_releases", nd_seen, 32'd3);

    // 5: make code without prefix
    sendByte(8'h1C);
    checkAll("make_1C");

    // 6: receiver disabled, then reset mid-frame with a pending break
    bus.rx_en = 1'b0;
    sendByte(8'h2B);
    checkAll("rx_disabled");
    bus.rx_en = 1'b1;
    sendByte(8'hF0);
    applyStimulus(BRK, 5);
    #20 reset = 1'b1;
    #100 reset = 1'b0;
    modelReset();
    #100;
    checkAll("after_reset");
    sendByte(8'h2B);
    checkAll("flag_cleared");
    sendByte(8'hF0);
    sendByte(8'h2B);
    checkAll("post_reset_2B");

    // Random frames, biased toward break prefixes
    for (int k = 0; k < 16; k++) begin
      rb = ($urandom_range(0, 2) == 0) ? BRK : 8'($urandom_range(0, 255));
      bus.rx_en = ($urandom_range(0, 5) != 0);
      sendByte(rb);
      checkAll("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
